// File: rtl/bch_data_checker_pkg.sv
// Shared definitions for the BCH bench blocks: default sizes and width helpers.
// Latency: n/a (constants and functions only).
// Backpressure: n/a.
package bch_data_checker_pkg;

  localparam int BCH_K_DEF     = 11;
  localparam int BCH_DEPTH_DEF = 8;
  localparam int BCH_CNT_W_DEF = 16;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a power-of-two depth; pointers wrap naturally.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bch_sync_fifo.sv
// Reference-word FIFO: show-ahead head from registered storage, explicit occupancy count.
// Latency: a pushed word is visible at head_o the cycle after the push (when it is the oldest).
// Backpressure: none internally; the caller must never push when full without popping, nor pop when empty.
module bch_sync_fifo
  import bch_data_checker_pkg::*;
#(
  parameter  int W     = BCH_K_DEF,
  parameter  int DEPTH = BCH_DEPTH_DEF,
  localparam int LVL_W = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     din_i,
  output logic [W-1:0]     head_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;

  // Occupancy moves only when exactly one of push/pop happens.
  always_comb begin
    level_d = level_q;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Storage carries no reset: contents are meaningless until counted by level_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/bch_data_checker.sv
// End-of-chain BCH checker: buffers encoder input words, compares each decoder output against the oldest.
// Latency: wrong_now/flags/checked/level update one cycle after the vdin/vdout that causes them.
// Backpressure: none; a push into a full FIFO without a pop is dropped and flagged, a pop on empty is flagged.
module bch_data_checker
  import bch_data_checker_pkg::*;
#(
  parameter  int K     = BCH_K_DEF,
  parameter  int DEPTH = BCH_DEPTH_DEF,
  parameter  int CNT_W = BCH_CNT_W_DEF,
  localparam int LVL_W = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [K-1:0]     din,
  input  logic             vdin,
  input  logic [K-1:0]     dout,
  input  logic             vdout,
  output logic             wrong_now,
  output logic             wrong,
  output logic             overflow,
  output logic             underflow,
  output logic [CNT_W-1:0] checked,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [K-1:0]     head;
  logic [LVL_W-1:0] fifo_level;
  logic             empty, full, push, pop, ovf_evt, unf_evt, miss;

  logic             wrong_now_q, wrong_now_d;
  logic             wrong_q, wrong_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] checked_q, checked_d;

  bch_sync_fifo #(
    .W     (K),
    .DEPTH (DEPTH)
  ) u_ref_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
    .level_o (fifo_level)
  );

  // Push/pop arbitration, compare and sticky-flag next state.
  always_comb begin
    empty   = (fifo_level == '0);
    full    = (fifo_level == FULL_LVL);
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    pop     = vdout && !empty;
    push    = vdin && (!full || vdout);
    ovf_evt = vdin && full && !vdout;
    // No bypass: a push into an empty FIFO is never compared in the same cycle.
    unf_evt = vdout && empty;
    miss    = unf_evt || (pop && (dout != head));

    wrong_now_d = miss;
    wrong_d     = wrong_q || miss || ovf_evt;
    overflow_d  = overflow_q || ovf_evt;
    underflow_d = underflow_q || unf_evt;
    checked_d   = checked_q;
    if (pop && (checked_q != CNT_MAX)) checked_d = checked_q + CNT_W'(1);
  end

  // Output and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrong_now_q <= 1'b0;
      wrong_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      checked_q   <= '0;
    end else begin
      wrong_now_q <= wrong_now_d;
      wrong_q     <= wrong_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      checked_q   <= checked_d;
    end
  end

  assign wrong_now = wrong_now_q;
  assign wrong     = wrong_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign checked   = checked_q;
  assign level     = fifo_level;

endmodule

// File: tb/tb_bch_data_checker.sv
// Self-checking bench for bch_data_checker: directed scenarios then random traffic vs a queue model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a (bench drives every input every cycle).
module tb_bch_data_checker;

  localparam int K     = 11;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic [K-1:0]     din;
  logic             vdin;
  logic [K-1:0]     dout;
  logic             vdout;
  logic             wrong_now;
  logic             wrong;
  logic             overflow;
  logic             underflow;
  logic [CNT_W-1:0] checked;
  logic [LVL_W-1:0] level;

  bch_data_checker #(
    .K     (K),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .vdin      (vdin),
    .dout      (dout),
    .vdout     (vdout),
    .wrong_now (wrong_now),
    .wrong     (wrong),
    .overflow  (overflow),
    .underflow (underflow),
    .checked   (checked),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of outstanding message words plus flags.
  logic [K-1:0]     mq [$];
  logic             m_wn, m_wrong, m_ovf, m_unf;
  int unsigned      m_chk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [K-1:0] head_or_rand();
    logic [K-1:0] r;
    r = K'($urandom);
    if (mq.size() > 0) r = mq[0];
    return r;
  endfunction

  // One clock of stimulus: update the model from the pre-edge state, clock, then compare.
  task automatic step(input logic r, input logic vi, input logic [K-1:0] di,
                      input logic vo, input logic [K-1:0] dv);
    int pre;
    logic [K-1:0] h;
    reset = r; vdin = vi; din = di; vdout = vo; dout = dv;
    if (r) begin
      mq.delete();
      m_wn = 0; m_wrong = 0; m_ovf = 0; m_unf = 0; m_chk = 0;
    end else begin
      pre  = mq.size();
      m_wn = 0;
      if (vo) begin
        if (pre == 0) begin
          m_unf = 1; m_wn = 1; m_wrong = 1;
        end else begin
          h = mq.pop_front();
          if (m_chk < (2 ** CNT_W) - 1) m_chk++;
          if (h != dv) begin m_wn = 1; m_wrong = 1; end
        end
      end
      if (vi) begin
        if (pre < DEPTH || vo) mq.push_back(di);
        else begin m_ovf = 1; m_wrong = 1; end
      end
    end
    @(posedge clk);
    #1;
    chk("wrong_now", 32'(wrong_now), 32'(m_wn));
    chk("wrong",     32'(wrong),     32'(m_wrong));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("checked",   32'(checked),   m_chk);
    chk("level",     32'(level),     32'(mq.size()));
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0);
  endtask

  initial begin
    logic [K-1:0] w;
    reset = 1; vdin = 0; din = '0; vdout = 0; dout = '0;
    m_wn = 0; m_wrong = 0; m_ovf = 0; m_unf = 0; m_chk = 0;

    // 1: reset held with both valids high
    step(1, 1, 11'h3C3, 1, 11'h3C3);
    step(1, 1, 11'h155, 1, 11'h2AA);

    // 2: two words, latency, two matching pops
    step(0, 1, 11'h5A3, 0, '0);
    step(0, 1, 11'h0F1, 0, '0);
    repeat (3) idle();
    step(0, 0, '0, 1, 11'h5A3);
    step(0, 0, '0, 1, 11'h0F1);
    idle();

    // 3: single-bit mismatch, one-cycle pulse, sticky wrong
    step(1, 0, '0, 0, '0);
    step(0, 1, 11'h123, 0, '0);
    step(0, 0, '0, 1, 11'h122);
    idle();
    idle();

    // 4: fill, overflow on ninth push, drain in order
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, K'(11'h100 + i * 37), 0, '0);
    step(0, 1, 11'h7AB, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1, head_or_rand());
    idle();

    // 5: underflow with simultaneous push (no bypass), then matching pop
    step(1, 0, '0, 0, '0);
    step(0, 1, 11'h7FF, 1, 11'h7FF);
    step(0, 0, '0, 1, 11'h7FF);
    idle();

    // 6: full FIFO streaming push+pop, then reset mid-run
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, K'($urandom), 0, '0);
    for (int i = 0; i < 20; i++) step(0, 1, K'($urandom), 1, head_or_rand());
    step(1, 1, K'($urandom), 1, head_or_rand());
    idle();

    // Random traffic: mostly matching pops, occasional corruption and resets
    for (int i = 0; i < 400; i++) begin
      w = head_or_rand();
      if ($urandom_range(0, 9) == 0) w = w ^ K'(1 << $urandom_range(0, K - 1));
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, K'($urandom),
           $urandom_range(0, 2) != 0, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
